// File: rtl/spi_reg_bridge.sv
// Command/register layer behind an SPI byte interface: each slave-select frame becomes
// a register write burst or read burst with address auto-increment.
module spi_reg_bridge #(
  parameter int unsigned AW     = 7,
  parameter logic [7:0]  STATUS = 8'hA5
) (
  input  logic          sysClk,
  input  logic          usrReset_n,
  input  logic          SS,
  input  logic          rxValid,
  input  logic [7:0]    rx,
  output logic [7:0]    tx,
  output logic          wrEn,
  output logic [AW-1:0] wrAddr,
  output logic [7:0]    wrData,
  output logic [AW-1:0] rdAddr,
  input  logic [7:0]    rdData,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    HOLD  = 2'd3
  } state_e;

  state_e        state_q,   state_d;
  logic          ss_meta_q, ss_meta_d;
  logic          ss_sync_q, ss_sync_d;
  logic          ss_prev_q, ss_prev_d;
  logic [1:0]    settle_q,  settle_d;
  logic          armed_q,   armed_d;
  logic [AW-1:0] addr_q,    addr_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          rd_upd_q,  rd_upd_d;
  logic [7:0]    tx_q,      tx_d;
  logic          wr_en_q,   wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          busy_q,    busy_d;

  logic          sync_ok;
  logic          ss_rise;
  logic          byte_ok;
  logic [AW-1:0] rx_addr;

  // The sync flops reset to "inactive", so their output only reflects the pin once
  // settle_q has filled. A frame is honoured only if SS was seen high first (armed_q).
  assign sync_ok = settle_q[1];
  assign ss_rise = ss_sync_q & ~ss_prev_q;
  assign byte_ok = rxValid & sync_ok & armed_q & ~ss_sync_q;
  assign rx_addr = rx[AW-1:0];

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave one
    // unassigned and infer a latch.
    state_d   = state_q;
    ss_meta_d = SS;
    ss_sync_d = ss_meta_q;
    ss_prev_d = ss_sync_q;
    settle_d  = {settle_q[0], 1'b1};
    armed_d   = armed_q;
    addr_d    = addr_q;
    rd_addr_d = rd_addr_q;
    rd_upd_d  = 1'b0;
    tx_d      = tx_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (sync_ok && ss_sync_q) armed_d = 1'b1;

    if (ss_rise) begin
      state_d = IDLE;
      tx_d    = STATUS;
    end else begin
      unique case (state_q)
        IDLE: begin
          tx_d = STATUS;
          if (sync_ok && !ss_sync_q && !armed_q) begin
            state_d = HOLD;
          end else if (byte_ok) begin
            if (rx[7]) begin
              state_d   = READ;
              rd_addr_d = rx_addr;
              rd_upd_d  = 1'b1;
              addr_d    = rx_addr + AW'(1);
            end else begin
              state_d = WRITE;
              addr_d  = rx_addr;
            end
          end
        end
        WRITE: begin
          tx_d = STATUS;
          if (byte_ok) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = rx;
            addr_d    = addr_q + AW'(1);
          end
        end
        READ: begin
          // The bank answers during the cycle after rdAddr moves.
          if (rd_upd_q) tx_d = rdData;
          if (byte_ok) begin
            rd_addr_d = addr_q;
            rd_upd_d  = 1'b1;
            addr_d    = addr_q + AW'(1);
          end
        end
        HOLD: ;
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == WRITE) || (state_d == READ);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the values
  // computed before this edge, independent of statement order.
  always_ff @(posedge sysClk) begin
    if (!usrReset_n) begin
      state_q   <= IDLE;
      ss_meta_q <= 1'b1;
      ss_sync_q <= 1'b1;
      ss_prev_q <= 1'b1;
      settle_q  <= 2'b00;
      armed_q   <= 1'b0;
      addr_q    <= '0;
      rd_addr_q <= '0;
      rd_upd_q  <= 1'b0;
      tx_q      <= STATUS;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ss_meta_q <= ss_meta_d;
      ss_sync_q <= ss_sync_d;
      ss_prev_q <= ss_prev_d;
      settle_q  <= settle_d;
      armed_q   <= armed_d;
      addr_q    <= addr_d;
      rd_addr_q <= rd_addr_d;
      rd_upd_q  <= rd_upd_d;
      tx_q      <= tx_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
    end
  end

  assign tx     = tx_q;
  assign wrEn   = wr_en_q;
  assign wrAddr = wr_addr_q;
  assign wrData = wr_data_q;
  assign rdAddr = rd_addr_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Self-checking bench for spi_reg_bridge: directed scenarios plus random frames,
// compared every cycle against a transaction-level model of the register protocol.
module tb_spi_reg_bridge;

  localparam logic [7:0] STATUS = 8'hA5;

  logic       sysClk;
  logic       usrReset_n;
  logic       SS;
  logic       rxValid;
  logic [7:0] rx;
  logic [7:0] tx;
  logic       wrEn;
  logic [6:0] wrAddr;
  logic [7:0] wrData;
  logic [6:0] rdAddr;
  logic [7:0] rdData;
  logic       busy;

  spi_reg_bridge #(.AW(7), .STATUS(STATUS)) dut (
    .sysClk     (sysClk),
    .usrReset_n (usrReset_n),
    .SS         (SS),
    .rxValid    (rxValid),
    .rx         (rx),
    .tx         (tx),
    .wrEn       (wrEn),
    .wrAddr     (wrAddr),
    .wrData     (wrData),
    .rdAddr     (rdAddr),
    .rdData     (rdData),
    .busy       (busy)
  );

  // Register bank: combinational read of a fixed pattern.
  assign rdData = {1'b0, rdAddr} ^ 8'hFF;

  initial begin
    sysClk = 1'b0;
    forever #5 sysClk = ~sysClk;
  end

  int cyc = 0;
  always @(posedge sysClk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_WRITE, M_READ, M_HOLD} mode_e;
  typedef enum {EV_WR, EV_RD, EV_TX, EV_BUSY} ev_kind_e;
  typedef struct {
    int         cyc;
    ev_kind_e   kind;
    logic [6:0] a;
    logic [7:0] d;
  } ev_t;

  ev_t         ev_q[$];
  mode_e       mode      = M_IDLE;
  logic [6:0]  m_addr    = 7'd0;
  logic        ss_ready  = 1'b0;
  logic        run_cmp   = 1'b0;
  int          skip_until = 0;
  logic        exp_wr    = 1'b0;
  logic [6:0]  exp_wa    = 7'd0;
  logic [7:0]  exp_wd    = 8'd0;
  logic [6:0]  exp_rd    = 7'd0;
  logic [7:0]  exp_tx    = STATUS;
  logic        exp_busy  = 1'b0;
  logic [15:0] wr_log[$];

  // A byte accepted at the current cycle: writes/rdAddr/busy show one cycle later,
  // read data on tx two cycles later.
  task automatic model_byte(input logic [7:0] b);
    case (mode)
      M_IDLE: begin
        ev_q.push_back('{cyc + 1, EV_BUSY, 7'd0, 8'd1});
        if (b[7]) begin
          mode = M_READ;
          ev_q.push_back('{cyc + 1, EV_RD, b[6:0], 8'd0});
          ev_q.push_back('{cyc + 2, EV_TX, 7'd0, {1'b0, b[6:0]} ^ 8'hFF});
          m_addr = b[6:0] + 7'd1;
        end else begin
          mode   = M_WRITE;
          m_addr = b[6:0];
        end
      end
      M_WRITE: begin
        ev_q.push_back('{cyc + 1, EV_WR, m_addr, b});
        m_addr = m_addr + 7'd1;
      end
      M_READ: begin
        ev_q.push_back('{cyc + 1, EV_RD, m_addr, 8'd0});
        ev_q.push_back('{cyc + 2, EV_TX, 7'd0, {1'b0, m_addr} ^ 8'hFF});
        m_addr = m_addr + 7'd1;
      end
      default: ;
    endcase
  endtask

  // Compare process: one sample per cycle, 1 time unit after the active edge.
  initial begin
    int idx;
    forever begin
      @(posedge sysClk);
      #1;
      exp_wr = 1'b0;
      idx = 0;
      while (idx < ev_q.size()) begin
        if (ev_q[idx].cyc <= cyc) begin
          case (ev_q[idx].kind)
            EV_WR:   begin exp_wr = 1'b1; exp_wa = ev_q[idx].a; exp_wd = ev_q[idx].d; end
            EV_RD:   exp_rd = ev_q[idx].a;
            EV_TX:   exp_tx = ev_q[idx].d;
            EV_BUSY: exp_busy = ev_q[idx].d[0];
            default: ;
          endcase
          ev_q.delete(idx);
        end else begin
          idx++;
        end
      end
      if (run_cmp) begin
        check("wrEn", 32'(wrEn), 32'(exp_wr));
        if (exp_wr) begin
          check("wrAddr", 32'(wrAddr), 32'(exp_wa));
          check("wrData", 32'(wrData), 32'(exp_wd));
        end
        check("rdAddr", 32'(rdAddr), 32'(exp_rd));
        if (cyc >= skip_until) begin
          check("tx", 32'(tx), 32'(exp_tx));
          check("busy", 32'(busy), 32'(exp_busy));
        end
        if (wrEn) wr_log.push_back({1'b0, wrAddr, wrData});
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge sysClk);
    rxValid = 1'b1;
    rx      = b;
    if (ss_ready) model_byte(b);
    @(negedge sysClk);
    rxValid = 1'b0;
    repeat (gap) @(negedge sysClk);
  endtask

  task automatic frame_begin();
    @(negedge sysClk);
    SS = 1'b0;
    repeat (4) @(negedge sysClk);
    ss_ready = 1'b1;
  endtask

  task automatic raise_ss();
    repeat (3) @(negedge sysClk);
    ss_ready   = 1'b0;
    SS         = 1'b1;
    mode       = M_IDLE;
    exp_busy   = 1'b0;
    exp_tx     = STATUS;
    skip_until = cyc + 4;
  endtask

  task automatic frame_end();
    raise_ss();
    repeat (4) @(negedge sysClk);
  endtask

  // Byte arrives in the same cycle the synchronised SS rise is seen.
  task automatic frame_end_with_byte(input logic [7:0] b);
    raise_ss();
    repeat (2) @(negedge sysClk);
    rxValid = 1'b1;
    rx      = b;
    @(negedge sysClk);
    rxValid = 1'b0;
    repeat (3) @(negedge sysClk);
  endtask

  task automatic do_reset();
    @(negedge sysClk);
    usrReset_n = 1'b0;
    ev_q.delete();
    mode     = SS ? M_IDLE : M_HOLD;
    exp_tx   = STATUS;
    exp_busy = 1'b0;
    exp_rd   = 7'd0;
    run_cmp  = 1'b1;
    repeat (2) @(negedge sysClk);
    usrReset_n = 1'b1;
    repeat (4) @(negedge sysClk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] cmd;
    int         n;
    usrReset_n = 1'b1;
    SS         = 1'b1;
    rxValid    = 1'b0;
    rx         = 8'h00;
    repeat (2) @(negedge sysClk);

    // T1 reset
    do_reset();
    check("t1_tx", 32'(tx), 32'h0000_00A5);
    check("t1_wrEn", 32'(wrEn), 32'h0);
    check("t1_busy", 32'(busy), 32'h0);
    check("t1_rdAddr", 32'(rdAddr), 32'h0);

    // T2 write burst
    wr_log.delete();
    frame_begin();
    send_byte(8'h05, 2);
    send_byte(8'h11, 2);
    check("t2_busy", 32'(busy), 32'h1);
    send_byte(8'h22, 2);
    send_byte(8'h33, 2);
    frame_end();
    check("t2_busy_end", 32'(busy), 32'h0);
    check("t2_tx_end", 32'(tx), 32'h0000_00A5);
    check("t2_nwr", 32'(wr_log.size()), 32'd3);
    if (wr_log.size() == 3) begin
      check("t2_w0", 32'(wr_log[0]), 32'h0511);
      check("t2_w1", 32'(wr_log[1]), 32'h0622);
      check("t2_w2", 32'(wr_log[2]), 32'h0733);
    end

    // T3 read burst
    wr_log.delete();
    frame_begin();
    send_byte(8'h90, 2);
    check("t3_tx0", 32'(tx), 32'h0000_00EF);
    send_byte(8'h00, 2);
    check("t3_tx1", 32'(tx), 32'h0000_00EE);
    send_byte(8'h00, 2);
    check("t3_tx2", 32'(tx), 32'h0000_00ED);
    check("t3_rdAddr", 32'(rdAddr), 32'h12);
    frame_end();
    check("t3_nwr", 32'(wr_log.size()), 32'd0);

    // T4 address wrap
    wr_log.delete();
    frame_begin();
    send_byte(8'h7F, 1);
    send_byte(8'hAA, 1);
    send_byte(8'hBB, 1);
    frame_end();
    check("t4_nwr", 32'(wr_log.size()), 32'd2);
    if (wr_log.size() == 2) begin
      check("t4_w0", 32'(wr_log[0]), 32'h7FAA);
      check("t4_w1", 32'(wr_log[1]), 32'h00BB);
    end

    // T5 byte coincident with frame end is dropped; next frame is fresh
    wr_log.delete();
    frame_begin();
    send_byte(8'h20, 2);
    send_byte(8'h44, 2);
    frame_end_with_byte(8'h55);
    frame_begin();
    send_byte(8'h30, 2);
    send_byte(8'h66, 2);
    frame_end();
    check("t5_nwr", 32'(wr_log.size()), 32'd2);
    if (wr_log.size() == 2) begin
      check("t5_w0", 32'(wr_log[0]), 32'h2044);
      check("t5_w1", 32'(wr_log[1]), 32'h3066);
    end

    // T6 reset mid read burst with SS held low
    wr_log.delete();
    frame_begin();
    send_byte(8'h85, 2);
    send_byte(8'h00, 2);
    repeat (3) @(negedge sysClk);
    do_reset();
    send_byte(8'h01, 2);
    send_byte(8'h02, 2);
    check("t6_busy", 32'(busy), 32'h0);
    check("t6_tx", 32'(tx), 32'h0000_00A5);
    frame_end();
    frame_begin();
    send_byte(8'h40, 2);
    send_byte(8'h77, 2);
    frame_end();
    check("t6_nwr", 32'(wr_log.size()), 32'd1);
    if (wr_log.size() == 1) check("t6_w0", 32'(wr_log[0]), 32'h4077);

    // Random frames, biased toward the top of the address space to exercise wrap
    for (int f = 0; f < 40; f++) begin
      cmd = 8'($urandom);
      if ($urandom_range(0, 2) == 0) cmd[6:2] = 5'h1F;
      n = int'($urandom_range(0, 5));
      frame_begin();
      send_byte(cmd, int'($urandom_range(0, 3)));
      for (int k = 0; k < n; k++) send_byte(8'($urandom), int'($urandom_range(0, 3)));
      frame_end();
    end
    check("events_drained", 32'(ev_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
